dram_write_arbiter: RTL

- Shares the single DRAM_Controller write-command port between NUM_REQ independent requesters, for example the camera BufferGearBox stream and a debug/pattern writer.
- Round-robin arbitration at command granularity. Exactly one command is in flight at a time.
- Sits between the requesters and dram_controller_0, in the m_axi_aclk domain.

---
 rtl/dram_arb_pkg.sv | 20 ++
 rtl/dram_write_arbiter_if.sv | 32 +++
 rtl/rr_select.sv | 45 ++++
 rtl/dram_write_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM write-command arbiter.
package dram_arb_pkg;

    // Arbiter command FSM states
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    // AXI burst length field width (beats-1)
    localparam int LEN_WIDTH = 8;

    // Index width for n requesters, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dram_write_arbiter_if.sv
// Requester-side command bus plus the controller write-command port.
// The arbiter is the master; the requesters/controller environment is the slave.
interface dram_write_arbiter_if #(
    parameter int NUM_REQ         = 2,
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 512
);
    // Requester side (flattened, requester i at [i*W +: W])
    logic [NUM_REQ-1:0]                            req_valid;
    logic [NUM_REQ*DRAM_ADDR_WIDTH-1:0]            req_addr;
    logic [NUM_REQ*dram_arb_pkg::LEN_WIDTH-1:0]    req_len;
    logic [NUM_REQ*DRAM_DATA_WIDTH-1:0]            req_data;
    logic [NUM_REQ-1:0]                            req_ack;

    // Controller side
    logic [DRAM_ADDR_WIDTH-1:0]                    dram_write_addr;
    logic [dram_arb_pkg::LEN_WIDTH-1:0]            dram_write_len;
    logic [DRAM_DATA_WIDTH-1:0]                    dram_write_data;
    logic                                          dram_write_en;
    logic                                          dram_write_busy;

    modport master (
        input  req_valid, req_addr, req_len, req_data, dram_write_busy,
        output req_ack, dram_write_addr, dram_write_len, dram_write_data, dram_write_en
    );

    modport slave (
        output req_valid, req_addr, req_len, req_data, dram_write_busy,
        input  req_ack, dram_write_addr, dram_write_len, dram_write_data, dram_write_en
    );

endinterface

// File: rtl/rr_select.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
// Purely combinational; the pointer is owned by the caller so a read arbiter can reuse it.
module rr_select #(
    parameter int NUM_REQ   = 2,
    parameter int IDX_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [IDX_WIDTH-1:0] grant,
    output logic                 any_valid
);

    // Requester index sitting at offset off from the pointer
    function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] p, input int off);
        int sum;
        sum = int'(p) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_WIDTH'(sum);
    endfunction

    logic [NUM_REQ*IDX_WIDTH-1:0] cand_flat;
    logic [NUM_REQ-1:0]           hit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_flat[gi*IDX_WIDTH +: IDX_WIDTH] = wrap_add(rr_ptr, gi);
            assign hit[gi] = req[cand_flat[gi*IDX_WIDTH +: IDX_WIDTH]];
        end
    endgenerate

    // Lowest offset from the pointer wins; scan downward so it is written last
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                grant     = cand_flat[k*IDX_WIDTH +: IDX_WIDTH];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_write_arbiter.sv
// Shares the DRAM controller write-command port among NUM_REQ requesters,
// round-robin at command granularity with one command in flight at a time.
module dram_write_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int DRAM_ADDR_WIDTH = 39,
    parameter int DRAM_DATA_WIDTH = 512,
    parameter int BUSY_TIMEOUT    = 15
) (
    input  logic                             m_axi_aclk,
    input  logic                             reset,
    dram_write_arbiter_if.master             bus,
    output logic [idx_width(NUM_REQ)-1:0]    grant_id,
    output logic                             timeout_err
);

    localparam int IDX_WIDTH = idx_width(NUM_REQ);
    localparam int CNT_WIDTH = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    arb_state_t state_reg, state_next;

    logic [IDX_WIDTH-1:0]       rr_ptr_reg;
    logic [IDX_WIDTH-1:0]       grant_id_reg;
    logic [CNT_WIDTH-1:0]       cnt_reg;
    logic                       timeout_err_reg;
    logic [DRAM_ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]       len_reg;
    logic [DRAM_DATA_WIDTH-1:0] data_reg;

    logic [IDX_WIDTH-1:0]       sel_grant;
    logic                       sel_valid;
    logic [CNT_WIDTH-1:0]       cnt_plus;
    logic                       load_cmd;
    logic                       cnt_clr;
    logic                       cnt_inc;
    logic                       set_err;
    logic [NUM_REQ-1:0]         ack_next;

    // Per-requester views of the flattened command fields
    logic [DRAM_ADDR_WIDTH-1:0] slot_addr [NUM_REQ];
    logic [LEN_WIDTH-1:0]       slot_len  [NUM_REQ];
    logic [DRAM_DATA_WIDTH-1:0] slot_data [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign slot_addr[gi] = bus.req_addr[gi*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
            assign slot_len[gi]  = bus.req_len[gi*LEN_WIDTH +: LEN_WIDTH];
            assign slot_data[gi] = bus.req_data[gi*DRAM_DATA_WIDTH +: DRAM_DATA_WIDTH];
        end
    endgenerate

    rr_select #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_select (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (sel_grant),
        .any_valid (sel_valid)
    );

    assign cnt_plus = cnt_reg + 1'b1;

    // FSM state register
    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and control strobes; a new grant waits for the controller to be free
    always_comb begin
        state_next = state_reg;
        load_cmd   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        set_err    = 1'b0;
        ack_next   = '0;
        case (state_reg)
            IDLE: begin
                if (sel_valid && !bus.dram_write_busy) begin
                    load_cmd   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                ack_next[grant_id_reg] = 1'b1;
                cnt_clr    = 1'b1;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.dram_write_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_plus == CNT_WIDTH'(BUSY_TIMEOUT)) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.dram_write_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, pointer advance, busy-rise timeout counter and sticky error
    always_ff @(posedge m_axi_aclk) begin
        if (reset) begin
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            cnt_reg         <= '0;
            timeout_err_reg <= 1'b0;
            addr_reg        <= '0;
            len_reg         <= '0;
            data_reg        <= '0;
        end else begin
            if (load_cmd) begin
                addr_reg     <= slot_addr[sel_grant];
                len_reg      <= slot_len[sel_grant];
                data_reg     <= slot_data[sel_grant];
                grant_id_reg <= sel_grant;
            end
            if (state_reg == ISSUE) begin
                rr_ptr_reg <= (grant_id_reg == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_reg + 1'b1;
            end
            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc) begin
                cnt_reg <= cnt_plus;
            end
            if (set_err) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign bus.dram_write_en   = (state_reg == ISSUE);
    assign bus.req_ack         = ack_next;
    assign bus.dram_write_addr = addr_reg;
    assign bus.dram_write_len  = len_reg;
    assign bus.dram_write_data = data_reg;
    assign grant_id            = grant_id_reg;
    assign timeout_err         = timeout_err_reg;

endmodule
